// File: rtl/id_hazard_controller.sv
// id_hazard_controller
//
// ID-stage hazard and issue controller for a 5-stage pipeline.
//
// The block keeps a shadow copy of the destination register of each
// instruction in EX, MEM and WB. From this it decides each cycle whether the
// ID instruction can issue. For every issued instruction it registers the
// EX operand-forwarding selects. It also raises an ID-stage bypass when WB
// writes a register in the same cycle that ID reads it. A multi-cycle
// mult/div instruction holds EX for MD_LATENCY cycles in total.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   ID_Valid          ID holds a real instruction
//   ID_Order          instruction word (rs = [25:21], rt = [20:16])
//   ID_UsesRs/Rt      the instruction reads rs / rt
//   ID_WriteReg       destination register
//   ID_RegWriteFlag   the instruction writes ID_WriteReg
//   ID_MemReadFlag    the instruction is a load
//   ID_MultiCycle     the instruction uses the mult/div unit
//   Flush             kill the ID instruction this cycle
//   ID_Stall          hold PC and IF/ID (combinational)
//   ID_Issue          ID instruction moves to EX at this edge (combinational)
//   ID_BypassA/B      use WB write data for rs / rt (combinational)
//   EX_FwdA/B         registered EX selects: 00 regfile, 01 MEM, 10 WB
//   EX_Hold, MD_Busy  multi-cycle instruction occupies EX

module id_hazard_controller #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_Valid,
    input  logic [31:0] ID_Order,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic [4:0]  ID_WriteReg,
    input  logic        ID_RegWriteFlag,
    input  logic        ID_MemReadFlag,
    input  logic        ID_MultiCycle,
    input  logic        Flush,
    output logic        ID_Stall,
    output logic        ID_Issue,
    output logic        ID_BypassA,
    output logic        ID_BypassB,
    output logic [1:0]  EX_FwdA,
    output logic [1:0]  EX_FwdB,
    output logic        EX_Hold,
    output logic        MD_Busy
);

    localparam int CW = $clog2(MD_LATENCY) + 1;

    logic [4:0] rs;
    logic [4:0] rt;

    // Only the source register fields are decoded here.
    logic unused_order_bits;

    // Pipeline shadow slots. MEM and WB never need the load flag, because
    // only a load sitting in EX can cause a stall.
    logic       ex_valid, ex_regwrite, ex_isload;
    logic [4:0] ex_wreg;
    logic       mem_valid, mem_regwrite;
    logic [4:0] mem_wreg;
    logic       wb_valid, wb_regwrite;
    logic [4:0] wb_wreg;

    logic [CW-1:0] cnt;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use;
    logic [1:0] fwd_a_next, fwd_b_next;

    // A slot produces r only when r is not register zero.
    function automatic logic slot_writes(input logic valid, input logic regwrite,
                                         input logic [4:0] wreg, input logic [4:0] r);
        return valid && regwrite && (wreg == r) && (r != 5'd0);
    endfunction

    assign rs = ID_Order[25:21];
    assign rt = ID_Order[20:16];
    assign unused_order_bits = ^{ID_Order[31:26], ID_Order[15:0]};

    assign EX_Hold = (cnt != '0);
    assign MD_Busy = EX_Hold;

    assign ex_hit_rs  = ID_UsesRs && slot_writes(ex_valid,  ex_regwrite,  ex_wreg,  rs);
    assign ex_hit_rt  = ID_UsesRt && slot_writes(ex_valid,  ex_regwrite,  ex_wreg,  rt);
    assign mem_hit_rs = ID_UsesRs && slot_writes(mem_valid, mem_regwrite, mem_wreg, rs);
    assign mem_hit_rt = ID_UsesRt && slot_writes(mem_valid, mem_regwrite, mem_wreg, rt);

    assign load_use = ex_isload && (ex_hit_rs || ex_hit_rt);

    // A flush overrides a stall, so a killed instruction never asserts ID_Stall.
    assign ID_Stall = ID_Valid && !Flush && (EX_Hold || load_use);
    assign ID_Issue = ID_Valid && !Flush && !ID_Stall;

    assign ID_BypassA = ID_UsesRs && slot_writes(wb_valid, wb_regwrite, wb_wreg, rs);
    assign ID_BypassB = ID_UsesRt && slot_writes(wb_valid, wb_regwrite, wb_wreg, rt);

    // Selects are named for the stage the producer occupies once the consumer
    // reaches EX. The EX-slot producer is checked first, so the youngest wins.
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (ex_hit_rs)       fwd_a_next = 2'b01;
        else if (mem_hit_rs) fwd_a_next = 2'b10;
        if (ex_hit_rt)       fwd_b_next = 2'b01;
        else if (mem_hit_rt) fwd_b_next = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_isload    <= 1'b0;
            ex_wreg      <= 5'd0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_wreg     <= 5'd0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_wreg      <= 5'd0;
            EX_FwdA      <= 2'b00;
            EX_FwdB      <= 2'b00;
            cnt          <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_wreg      <= mem_wreg;

            // While EX is held, the held instruction stays in EX and MEM
            // receives bubbles until the instruction finally leaves.
            if (EX_Hold) begin
                mem_valid    <= 1'b0;
                mem_regwrite <= 1'b0;
                mem_wreg     <= 5'd0;
            end else begin
                mem_valid    <= ex_valid;
                mem_regwrite <= ex_regwrite;
                mem_wreg     <= ex_wreg;
                if (ID_Issue) begin
                    ex_valid    <= 1'b1;
                    ex_regwrite <= ID_RegWriteFlag;
                    ex_isload   <= ID_MemReadFlag;
                    ex_wreg     <= ID_WriteReg;
                    EX_FwdA     <= fwd_a_next;
                    EX_FwdB     <= fwd_b_next;
                end else begin
                    ex_valid    <= 1'b0;
                    ex_regwrite <= 1'b0;
                    ex_isload   <= 1'b0;
                    ex_wreg     <= 5'd0;
                    EX_FwdA     <= 2'b00;
                    EX_FwdB     <= 2'b00;
                end
            end

            // The issue edge counts as the first EX cycle, so the hold lasts
            // MD_LATENCY-1 further edges. With a latency of 1 there is no hold.
            if (ID_Issue && ID_MultiCycle)
                cnt <= CW'(MD_LATENCY - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_controller.sv
// tb_id_hazard_controller
//
// Directed testbench for id_hazard_controller with MD_LATENCY = 4.
// Each scenario drives ID fields, checks the combinational issue, stall and
// bypass outputs before the edge, then checks the registered selects after
// the edge.

module tb_id_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic        ID_Valid;
    logic [31:0] ID_Order;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic [4:0]  ID_WriteReg;
    logic        ID_RegWriteFlag;
    logic        ID_MemReadFlag;
    logic        ID_MultiCycle;
    logic        Flush;
    logic        ID_Stall;
    logic        ID_Issue;
    logic        ID_BypassA;
    logic        ID_BypassB;
    logic [1:0]  EX_FwdA;
    logic [1:0]  EX_FwdB;
    logic        EX_Hold;
    logic        MD_Busy;

    int tests_run;
    int tests_failed;

    id_hazard_controller #(.MD_LATENCY(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_Valid        (ID_Valid),
        .ID_Order        (ID_Order),
        .ID_UsesRs       (ID_UsesRs),
        .ID_UsesRt       (ID_UsesRt),
        .ID_WriteReg     (ID_WriteReg),
        .ID_RegWriteFlag (ID_RegWriteFlag),
        .ID_MemReadFlag  (ID_MemReadFlag),
        .ID_MultiCycle   (ID_MultiCycle),
        .Flush           (Flush),
        .ID_Stall        (ID_Stall),
        .ID_Issue        (ID_Issue),
        .ID_BypassA      (ID_BypassA),
        .ID_BypassB      (ID_BypassB),
        .EX_FwdA         (EX_FwdA),
        .EX_FwdB         (EX_FwdB),
        .EX_Hold         (EX_Hold),
        .MD_Busy         (MD_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rs,
                                 input logic uses_rt, input logic [4:0] wreg,
                                 input logic regwrite, input logic memread,
                                 input logic multi, input logic flush);
        ID_Valid        = valid;
        ID_Order        = {6'h00, rs, rt, 16'h0000};
        ID_UsesRs       = uses_rs;
        ID_UsesRt       = uses_rt;
        ID_WriteReg     = wreg;
        ID_RegWriteFlag = regwrite;
        ID_MemReadFlag  = memread;
        ID_MultiCycle   = multi;
        Flush           = flush;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [1:0] dist_fwd [1:4];
    logic       dist_byp [1:4];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        dist_fwd[1] = 2'b01; dist_fwd[2] = 2'b10; dist_fwd[3] = 2'b00; dist_fwd[4] = 2'b00;
        dist_byp[1] = 1'b0;  dist_byp[2] = 1'b0;  dist_byp[3] = 1'b1;  dist_byp[4] = 1'b0;

        // Reset state
        rst_n = 1'b0;
        idle(2);
        checkOutput("reset_fwdA", EX_FwdA, 2'b00);
        checkOutput("reset_fwdB", EX_FwdB, 2'b00);
        checkOutput("reset_hold", EX_Hold, 1'b0);
        checkOutput("reset_busy", MD_Busy, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_stall", ID_Stall, 1'b0);
        checkOutput("reset_issue", ID_Issue, 1'b1);
        idle(4);

        // Dependency distance 1..4 on rs = r3
        for (int d = 1; d <= 4; d++) begin
            applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            idle(d - 1);
            applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("dist%0d_stall", d), ID_Stall, 1'b0);
            checkOutput($sformatf("dist%0d_bypA", d), ID_BypassA, dist_byp[d]);
            tick();
            checkOutput($sformatf("dist%0d_fwdA", d), EX_FwdA, dist_fwd[d]);
            idle(4);
        end

        // Back-to-back producers of r3: the younger one in EX wins
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("b2b_fwdA", EX_FwdA, 2'b01);
        idle(4);

        // Load-use on rt = r5
        applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_stall1", ID_Stall, 1'b1);
        checkOutput("lu_issue1", ID_Issue, 1'b0);
        tick();
        checkOutput("lu_bubble_fwdB", EX_FwdB, 2'b00);
        checkOutput("lu_stall2", ID_Stall, 1'b0);
        checkOutput("lu_issue2", ID_Issue, 1'b1);
        tick();
        checkOutput("lu_fwdB", EX_FwdB, 2'b10);
        checkOutput("lu_fwdA", EX_FwdA, 2'b00);
        idle(4);

        // Register zero: a load of r0 followed by a reader of r0
        applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("r0_stall", ID_Stall, 1'b0);
        checkOutput("r0_issue", ID_Issue, 1'b1);
        checkOutput("r0_bypA", ID_BypassA, 1'b0);
        checkOutput("r0_bypB", ID_BypassB, 1'b0);
        tick();
        checkOutput("r0_fwdA", EX_FwdA, 2'b00);
        checkOutput("r0_fwdB", EX_FwdB, 2'b00);
        idle(4);

        // Multi-cycle mult r7 followed by a dependent add
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("md_issue", ID_Issue, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("md_hold%0d", i), EX_Hold, 1'b1);
            checkOutput($sformatf("md_busy%0d", i), MD_Busy, 1'b1);
            checkOutput($sformatf("md_stall%0d", i), ID_Stall, 1'b1);
            tick();
        end
        checkOutput("md_hold_end", EX_Hold, 1'b0);
        checkOutput("md_issue_dep", ID_Issue, 1'b1);
        tick();
        checkOutput("md_fwdA", EX_FwdA, 2'b01);
        idle(4);

        // Flush during a load-use stall
        applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("fl_stall", ID_Stall, 1'b0);
        checkOutput("fl_issue", ID_Issue, 1'b0);
        tick();
        checkOutput("fl_fwdA", EX_FwdA, 2'b00);
        checkOutput("fl_fwdB", EX_FwdB, 2'b00);
        // EX is a bubble and the load now sits in MEM, so r6 has no producer.
        applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fl_next_stall", ID_Stall, 1'b0);
        tick();
        checkOutput("fl_next_fwdA", EX_FwdA, 2'b10);
        checkOutput("fl_next_fwdB", EX_FwdB, 2'b00);
        idle(4);

        // Reset while the multi-cycle counter is at 2
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle(1);
        checkOutput("rst_md_pre_hold", EX_Hold, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rst_md_hold", EX_Hold, 1'b0);
        checkOutput("rst_md_busy", MD_Busy, 1'b0);
        checkOutput("rst_md_fwdA", EX_FwdA, 2'b00);
        checkOutput("rst_md_fwdB", EX_FwdB, 2'b00);
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_md_issue", ID_Issue, 1'b1);
        checkOutput("rst_md_stall", ID_Stall, 1'b0);
        tick();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
